// File: rtl/vending_pkg.sv
// Shared types for the multi-product vending controller: FSM states and status codes.
package vending_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FUNDS   = 2'd1;
  localparam logic [1:0] ERR_SOLDOUT = 2'd2;
  localparam logic [1:0] ERR_COIN    = 2'd3;

endpackage

// File: rtl/vending_table.sv
// Price table (and per-product stock when VENDING_STOCK_EN is defined).
// Written by index during load; read combinationally by a 0-based product index.
module vending_table
  import vending_pkg::*;
#(
  parameter int N_PROD     = 4,
  parameter int MW         = 8,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 5,
  parameter int SW         = $clog2(N_PROD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [SW-1:0] wr_idx_i,
  input  logic [MW-1:0] wr_data_i,
  input  logic          stock_load_i,
  input  logic [SW-1:0] rd_idx_i,
  input  logic          dec_en_i,
  output logic [MW-1:0] price_o,
  output logic          stock_zero_o
);

  logic [MW-1:0] price_q [N_PROD];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_PROD; i++) price_q[i] <= '0;
    end else if (wr_en_i) begin
      for (int i = 0; i < N_PROD; i++)
        if (wr_idx_i == SW'(i)) price_q[i] <= wr_data_i;
    end
  end

  // Loop-based mux keeps the select width independent of N_PROD.
  always_comb begin
    price_o = '0;
    for (int i = 0; i < N_PROD; i++)
      if (rd_idx_i == SW'(i)) price_o = price_q[i];
  end

`ifdef VENDING_STOCK_EN
  logic [STOCK_W-1:0] stock_q [N_PROD];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= '0;
    end else if (stock_load_i) begin
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else if (dec_en_i) begin
      for (int i = 0; i < N_PROD; i++)
        if (rd_idx_i == SW'(i)) stock_q[i] <= stock_q[i] - STOCK_W'(1);
    end
  end

  always_comb begin
    stock_zero_o = 1'b0;
    for (int i = 0; i < N_PROD; i++)
      if (rd_idx_i == SW'(i)) stock_zero_o = (stock_q[i] == '0);
  end
`else
  logic unused_stock;
  assign unused_stock = dec_en_i ^ stock_load_i ^ (STOCK_W > 0) ^ (STOCK_INIT > 0);
  assign stock_zero_o = 1'b0;
`endif

endmodule

// File: rtl/vending_multi.sv
// Multi-product vending controller: loads a price table, then accepts coins, vends and refunds.
// Define VENDING_STOCK_EN to enable per-product stock tracking and sold-out reporting.
module vending_multi
  import vending_pkg::*;
#(
  parameter int N_PROD     = 4,
  parameter int MW         = 8,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 5,
  localparam int SW        = $clog2(N_PROD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [MW-1:0] DI,
  input  logic [MW-1:0] MI,
  input  logic [SW-1:0] sel,
  input  logic          re,
  output logic [MW-1:0] MO,
  output logic [SW-1:0] PO,
  output logic [1:0]    err,
  output logic          ready
);

  state_t        state_q, state_d;
  logic [SW-1:0] idx_q, idx_d;
  logic [MW-1:0] credit_q, credit_d;
  logic [MW-1:0] mo_q, mo_d;
  logic [SW-1:0] po_q, po_d;
  logic [1:0]    err_q, err_d;
  logic          ready_q, ready_d;

  logic          wr_en, stock_load, dec_en, stock_zero, sel_ok;
  logic [SW-1:0] rd_idx;
  logic [MW-1:0] price;
  logic [MW:0]   sum;

  assign sel_ok = (sel != '0) && (int'(sel) <= N_PROD);
  assign rd_idx = sel_ok ? sel - SW'(1) : '0;
  assign sum    = {1'b0, credit_q} + {1'b0, MI};

  vending_table #(
    .N_PROD(N_PROD), .MW(MW), .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT), .SW(SW)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en),
    .wr_idx_i    (idx_q),
    .wr_data_i   (DI),
    .stock_load_i(stock_load),
    .rd_idx_i    (rd_idx),
    .dec_en_i    (dec_en),
    .price_o     (price),
    .stock_zero_o(stock_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      credit_q <= '0;
      mo_q     <= '0;
      po_q     <= '0;
      err_q    <= ERR_NONE;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      credit_q <= credit_d;
      mo_q     <= mo_d;
      po_q     <= po_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    credit_d   = credit_q;
    ready_d    = ready_q;
    mo_d       = '0;
    po_d       = '0;
    err_d      = ERR_NONE;
    wr_en      = 1'b0;
    stock_load = 1'b0;
    dec_en     = 1'b0;
    unique case (state_q)
      LOAD: begin
        wr_en = 1'b1;
        if (idx_q == SW'(N_PROD - 1)) begin
          state_d    = RUN;
          idx_d      = '0;
          stock_load = 1'b1;
          ready_d    = 1'b1;
        end else begin
          idx_d = idx_q + SW'(1);
        end
        if (MI != '0) begin
          mo_d  = MI;
          err_d = ERR_COIN;
        end
      end
      RUN: begin
        // A coin that would overflow credit is bounced and the rest of the cycle ignored.
        if (sum[MW]) begin
          mo_d  = MI;
          err_d = ERR_COIN;
        end else if (re) begin
          mo_d     = sum[MW-1:0];
          credit_d = '0;
        end else if (sel_ok) begin
          if (stock_zero) begin
            err_d    = ERR_SOLDOUT;
            credit_d = sum[MW-1:0];
          end else if (sum >= {1'b0, price}) begin
            po_d     = sel;
            mo_d     = sum[MW-1:0] - price;
            credit_d = '0;
            dec_en   = 1'b1;
          end else begin
            err_d    = ERR_FUNDS;
            credit_d = sum[MW-1:0];
          end
        end else begin
          credit_d = sum[MW-1:0];
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign MO    = mo_q;
  assign PO    = po_q;
  assign err   = err_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_vending_multi.sv
// Directed bench for vending_multi with a transaction-level model checked every cycle.
module tb_vending_multi;

  localparam int N  = 3;
  localparam int MW = 8;
  localparam int SW = 2;
  localparam int SI = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [MW-1:0] DI, MI, MO;
  logic [SW-1:0] sel, PO;
  logic          re, ready;
  logic [1:0]    err;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: plain integers, one price/stock entry per product (1-based)
  int m_price [1:N];
  int m_stock [1:N];
  int m_credit = 0;
  int m_loaded = 0;
  bit m_ready  = 0;
  int e_mo = 0, e_po = 0, e_err = 0;
  bit e_ready = 0;
  bit chk_en  = 0;

  vending_multi #(.N_PROD(N), .MW(MW), .STOCK_W(4), .STOCK_INIT(SI)) dut (
    .clk(clk), .rst(rst), .DI(DI), .MI(MI), .sel(sel), .re(re),
    .MO(MO), .PO(PO), .err(err), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int sum, k;
    if (!rst) begin
      m_credit = 0; m_loaded = 0; m_ready = 0;
      for (int i = 1; i <= N; i++) begin m_price[i] = 0; m_stock[i] = 0; end
      e_mo = 0; e_po = 0; e_err = 0; e_ready = 0;
    end else begin
      e_mo = 0; e_po = 0; e_err = 0;
      if (!m_ready) begin
        m_loaded++;
        m_price[m_loaded] = int'(DI);
        if (m_loaded == N) begin
          m_ready = 1;
          for (int i = 1; i <= N; i++) m_stock[i] = SI;
        end
        if (MI != 0) begin e_mo = int'(MI); e_err = 3; end
      end else begin
        sum = m_credit + int'(MI);
        k   = int'(sel);
        if (sum > 255) begin
          e_mo = int'(MI); e_err = 3;
        end else if (re) begin
          e_mo = sum; m_credit = 0;
        end else if (k >= 1 && k <= N) begin
`ifdef VENDING_STOCK_EN
          if (m_stock[k] == 0) begin
            e_err = 2; m_credit = sum;
          end else
`endif
          if (sum >= m_price[k]) begin
            e_po = k; e_mo = sum - m_price[k]; m_credit = 0; m_stock[k]--;
          end else begin
            e_err = 1; m_credit = sum;
          end
        end else begin
          m_credit = sum;
        end
      end
      e_ready = m_ready;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("MO", int'(MO), e_mo);
      cmp("PO", int'(PO), e_po);
      cmp("err", int'(err), e_err);
      cmp("ready", int'(ready), int'(e_ready));
    end
  end

  task automatic step(input bit r, input int di, input int mi, input int s, input bit rr);
    rst = r; DI = MW'(di); MI = MW'(mi); sel = SW'(s); re = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; DI = '0; MI = '0; sel = '0; re = 1'b0;
    step(0, 0, 0, 0, 0);
    chk_en = 1;
    cmp("rst_ready", int'(ready), 0);
    cmp("rst_MO", int'(MO), 0);

    // Load with a coin bounced on the first cycle
    step(1, 10, 5, 0, 0);
    cmp("load_coin_MO", int'(MO), 5);
    cmp("load_coin_err", int'(err), 3);
    cmp("load_not_ready", int'(ready), 0);
    step(1, 20, 0, 0, 0);
    step(1, 30, 0, 0, 0);
    cmp("ready_after_load", int'(ready), 1);

    // Buy product 2 with exact arithmetic 20+5-20
    step(1, 0, 20, 0, 0);
    step(1, 0, 5, 2, 0);
    cmp("buy2_PO", int'(PO), 2);
    cmp("buy2_MO", int'(MO), 5);
    cmp("buy2_credit", m_credit, 0);

    // Insufficient credit, then refund
    step(1, 0, 10, 3, 0);
    cmp("funds_err", int'(err), 1);
    cmp("funds_PO", int'(PO), 0);
    step(1, 0, 0, 0, 1);
    cmp("refund_MO", int'(MO), 10);

    // Overflow bounce keeps credit
    step(1, 0, 250, 0, 0);
    step(1, 0, 10, 0, 0);
    cmp("ovf_MO", int'(MO), 10);
    cmp("ovf_err", int'(err), 3);
    cmp("ovf_credit", m_credit, 250);
    step(1, 0, 0, 0, 1);
    cmp("ovf_refund", int'(MO), 250);

    // Exactly full credit is not an overflow
    step(1, 0, 255, 0, 0);
    cmp("max_err", int'(err), 0);
    step(1, 0, 0, 0, 1);
    cmp("max_refund", int'(MO), 255);

    // Refund wins over a simultaneous selection
    step(1, 0, 25, 2, 1);
    cmp("prio_MO", int'(MO), 25);
    cmp("prio_PO", int'(PO), 0);

    // Repeated purchases of product 1
    step(1, 0, 10, 1, 0);
    cmp("stk1_PO", int'(PO), 1);
    step(1, 0, 10, 1, 0);
    cmp("stk2_PO", int'(PO), 1);
    step(1, 0, 10, 1, 0);
`ifdef VENDING_STOCK_EN
    cmp("soldout_err", int'(err), 2);
    cmp("soldout_PO", int'(PO), 0);
    cmp("soldout_credit", m_credit, 10);
    step(1, 0, 0, 0, 1);
    cmp("soldout_refund", int'(MO), 10);
`else
    cmp("nostock_PO", int'(PO), 1);
    step(1, 0, 0, 0, 1);
    cmp("nostock_refund", int'(MO), 0);
`endif

    // Reset mid-RUN with credit 40
    step(1, 0, 40, 0, 0);
    step(0, 0, 0, 0, 0);
    cmp("midrun_ready", int'(ready), 0);
    cmp("midrun_MO", int'(MO), 0);
    step(1, 0, 0, 0, 1);
    cmp("after_rst_re_MO", int'(MO), 0);

    // Reset mid-load, then reload with a zero price for product 1
    step(1, 20, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 20, 0, 0, 0);
    step(1, 30, 0, 0, 0);
    cmp("reload_ready", int'(ready), 1);
    step(1, 0, 0, 1, 0);
    cmp("free_PO", int'(PO), 1);
    cmp("free_MO", int'(MO), 0);
    cmp("free_err", int'(err), 0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_multi.md
VENDING_MULTI -- requirements
Module: vending_multi

Interface
REQ-001 The block SHALL have parameter N_PROD, default 4, meaning number of products (2..15).
REQ-002 The block SHALL have parameter MW, default 8, meaning money/price width in bits.
REQ-003 The block SHALL have parameter STOCK_W, default 4, meaning per-product stock counter width.
REQ-004 The block SHALL have parameter STOCK_INIT, default 5, meaning stock loaded per product at end of price load.
REQ-005 Port clk  input  1  meaning system clock; all state changes on rising edge.
REQ-006 Port rst  input  1  meaning reset; one clock, reset is synchronous and active-low.
REQ-007 Port DI  input  MW  meaning price data during LOAD.
REQ-008 Port MI  input  MW  meaning coin value inserted this cycle (0 = none).
REQ-009 Port sel  input  SW=$clog2(N_PROD+1)  meaning product request, 0 = none, k = product k.
REQ-010 Port re  input  1  meaning refund request.
REQ-011 Port MO  output  MW  meaning change/refund/returned-coin value, valid one cycle.
REQ-012 Port PO  output  SW  meaning dispensed product index, 0 = none, valid one cycle.
REQ-013 Port err  output  2  meaning one-cycle status: 0 ok, 1 insufficient credit, 2 sold out, 3 coin rejected.
REQ-014 Port ready  output  1  meaning 1 once price table loaded (state RUN).

Function
REQ-015 States SHALL be LOAD and RUN; after reset state is LOAD with index 0.
REQ-016 In LOAD, each cycle SHALL store DI into price[index], increment index; after N_PROD cycles SHALL enter RUN and set ready.
REQ-017 In LOAD, MI≠0 SHALL be returned on MO next cycle with err=3; sel and re ignored.
REQ-018 All outputs SHALL be registered: response appears on the cycle after the sampling edge, MO/PO/err default 0 every cycle otherwise.
REQ-019 In RUN, sum = credit + MI SHALL be computed at MW+1 bits; if sum exceeds 2^MW-1, MO=MI, err=3, credit unchanged, sel and re ignored that cycle.
REQ-020 re=1 SHALL have priority over sel: MO=sum, PO=0, credit cleared.
REQ-021 sel=k with sum ≥ price[k-1] (and stock nonzero when enabled) SHALL give PO=k, MO=sum-price[k-1], credit cleared.
REQ-022 sel=k with sum < price[k-1] SHALL give err=1, PO=0, MO=0, credit=sum (retained).
REQ-023 sel > N_PROD SHALL be treated as sel=0.
REQ-024 sel=0, re=0 SHALL accumulate credit=sum with no output.
REQ-025 Price 0 SHALL be legal; purchase with zero credit succeeds, MO=0.

Reset
REQ-026 With rst=0 at a rising edge: credit, index, prices, stock, MO, PO, err, ready SHALL clear to 0, state LOAD, regardless of state (mid-load or mid-RUN; credit is lost).

Configuration
REQ-027 Macro VENDING_STOCK_EN defined: per-product stock counters SHALL load STOCK_INIT on LOAD→RUN, decrement on each successful vend, and sel=k with stock 0 SHALL give err=2, PO=0, MO=0, credit retained (sold-out checked before credit).
REQ-028 Macro VENDING_STOCK_EN undefined: no stock storage, err=2 never produced, STOCK_W/STOCK_INIT unused.

Structure
REQ-029 Package vending_pkg SHALL hold the state enum (LOAD, RUN) and err code constants (ERR_NONE, ERR_FUNDS, ERR_SOLDOUT, ERR_COIN).
REQ-030 Sub-module vending_table SHALL hold price (and stock when enabled) arrays with write-index, read-by-sel and decrement ports.

Verification (N_PROD=3, MW=8, STOCK_INIT=2, prices 10,20,30)
REQ-031 Reset, DI=10,20,30 over 3 cycles -> ready=1 on 4th cycle; MI=5 during LOAD -> MO=5, err=3.
REQ-032 MI=20 then sel=2 with MI=5 same cycle -> PO=2, MO=5, credit 0.
REQ-033 MI=10, sel=3 -> err=1, PO=0; then re=1 -> MO=10, PO=0.
REQ-034 Credit 250, MI=10 -> MO=10, err=3, credit stays 250; then re -> MO=250.
REQ-035 VENDING_STOCK_EN: three buys of product 1 at MI=10 -> PO=1, PO=1, then err=2 with credit 10 retained.
REQ-036 rst=0 mid-RUN with credit 40 -> outputs 0, ready=0, subsequent re -> MO=0.
